// File: rtl/can_pkg.sv
// Shared CAN constants: bit-stuffing defaults, destuffer state encoding, CRC-15 polynomial.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package can_pkg;

    // Identical consecutive bits after which the transmitter inserts a stuff bit.
    localparam int CAN_STUFF_LEN = 5;

    // CAN CRC-15 generator polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.
    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        COUNT        = 2'd1,
        EXPECT_STUFF = 2'd2,
        ERROR        = 2'd3
    } destuff_state_t;

endpackage

// File: rtl/can_bit_destuff_if.sv
// Bus between the bit sampler and the destuffer, and from the destuffer to the CRC stage.
// Latency: n/a (wires only).
// Backpressure: none; every strobe is a single-cycle pulse that must be consumed.
interface can_bit_destuff_if #(
    parameter int CNT_W = 8
);
    // sampler -> destuffer
    logic             sample_tick;   // rx_bit is a fresh bus sample
    logic             rx_bit;        // sampled bus level, 0 = dominant
    logic             stuff_enable;  // current bit lies in SOF..CRC
    logic             frame_start;   // SOF sample, re-arms the block
    // destuffer -> CRC stage / controller
    logic             bit_tick;      // data_out carries a destuffed bit
    logic             data_out;      // destuffed bit, held between ticks
    logic             stuff_drop;    // a stuff bit was removed
    logic             stuff_error;   // stuff rule violated
    logic             error_flag;    // sticky violation, cleared by frame_start
    logic [CNT_W-1:0] stuff_count;   // stuff bits removed this frame, saturating

    modport master (
        output sample_tick, rx_bit, stuff_enable, frame_start,
        input  bit_tick, data_out, stuff_drop, stuff_error, error_flag, stuff_count
    );

    modport slave (
        input  sample_tick, rx_bit, stuff_enable, frame_start,
        output bit_tick, data_out, stuff_drop, stuff_error, error_flag, stuff_count
    );

endinterface

// File: rtl/can_bit_destuff.sv
// CAN bit destuffer: removes stuff bits after STUFF_LEN identical bits, flags stuff violations.
// Latency: every output strobe is registered, 1 cycle after the causing sample_tick.
// Backpressure: none; consumer must accept a bit_tick whenever it fires.
// Ports: clk, rst (async active-low), bus (slave side of can_bit_destuff_if).
module can_bit_destuff
    import can_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    can_bit_destuff_if.slave bus
);

    localparam int               RUN_W   = $clog2(STUFF_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);

    destuff_state_t   state;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             last_bit;
    logic             data_q;
    logic             bit_tick_q;
    logic             stuff_drop_q;
    logic             stuff_error_q;
    logic             error_flag_q;
    logic [CNT_W-1:0] stuff_count_q;

    // run_cnt == 0 means no run is open (after IDLE), so the next bit always
    // starts a fresh run even if it happens to equal the stale last_bit.
    always_comb begin
        run_next = RUN_ONE;
        if (bus.rx_bit == last_bit && run_cnt != '0) begin
            run_next = run_cnt + RUN_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            run_cnt       <= '0;
            last_bit      <= 1'b1;
            data_q        <= 1'b1;
            bit_tick_q    <= 1'b0;
            stuff_drop_q  <= 1'b0;
            stuff_error_q <= 1'b0;
            error_flag_q  <= 1'b0;
            stuff_count_q <= '0;
        end else begin
            bit_tick_q    <= 1'b0;
            stuff_drop_q  <= 1'b0;
            stuff_error_q <= 1'b0;

            if (bus.frame_start) begin
                // SOF overrides any pending expectation or error from the last frame.
                error_flag_q  <= 1'b0;
                stuff_count_q <= '0;
                run_cnt       <= '0;
                state         <= IDLE;
                if (bus.sample_tick) begin
                    bit_tick_q <= 1'b1;
                    data_q     <= bus.rx_bit;
                    if (bus.stuff_enable) begin
                        run_cnt  <= RUN_ONE;
                        last_bit <= bus.rx_bit;
                        state    <= (RUN_ONE == RUN_MAX) ? EXPECT_STUFF : COUNT;
                    end
                end
            end else if (bus.sample_tick) begin
                case (state)
                    IDLE, COUNT: begin
                        bit_tick_q <= 1'b1;
                        data_q     <= bus.rx_bit;
                        if (bus.stuff_enable) begin
                            run_cnt  <= run_next;
                            last_bit <= bus.rx_bit;
                            state    <= (run_next == RUN_MAX) ? EXPECT_STUFF : COUNT;
                        end else begin
                            run_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                    // stuff_enable is ignored here: the stuff bit after the
                    // last CRC bit arrives once the region has already closed.
                    EXPECT_STUFF: begin
                        if (bus.rx_bit != last_bit) begin
                            stuff_drop_q <= 1'b1;
                            if (stuff_count_q != '1) begin
                                stuff_count_q <= stuff_count_q + CNT_W'(1);
                            end
                            run_cnt  <= RUN_ONE;   // the stuff bit opens the next run
                            last_bit <= bus.rx_bit;
                            state    <= COUNT;
                        end else begin
                            stuff_error_q <= 1'b1;
                            error_flag_q  <= 1'b1;
                            state         <= ERROR;
                        end
                    end
                    default: begin
                        // ERROR: samples are discarded until the next SOF.
                    end
                endcase
            end
        end
    end

    assign bus.bit_tick    = bit_tick_q;
    assign bus.data_out    = data_q;
    assign bus.stuff_drop  = stuff_drop_q;
    assign bus.stuff_error = stuff_error_q;
    assign bus.error_flag  = error_flag_q;
    assign bus.stuff_count = stuff_count_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Self-checking bench for can_bit_destuff: directed frames plus random frames vs. a window model.
// Latency: expects each output strobe one cycle after its sample.
// Backpressure: none; monitor consumes every strobe.
module tb_can_bit_destuff;
    import can_pkg::*;

    localparam int CNT_W   = 8;
    localparam int SL      = CAN_STUFF_LEN;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    can_bit_destuff_if #(.CNT_W(CNT_W)) bus ();

    can_bit_destuff #(.STUFF_LEN(SL), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected output event: kind 0 = data bit, 1 = stuff dropped, 2 = stuff error.
    typedef struct {
        int   kind;
        logic dat;
        int   cnt;
        logic flag;
        time  due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: a sliding window over the bits of the current stuffed
    // stretch (data and stuff bits). A stuff bit is due whenever the last SL
    // bits in the window are identical.
    logic win[$];
    int   m_cnt  = 0;
    logic m_err  = 1'b0;
    logic m_dout = 1'b1;

    function automatic int sat(input int c);
        return (c > CNT_MAX) ? CNT_MAX : c;
    endfunction

    function automatic bit stuff_due();
        if (win.size() < SL) return 1'b0;
        for (int i = 1; i < SL; i++)
            if (win[win.size() - 1 - i] != win[win.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endfunction

    task automatic push_exp(input int kind);
        exp_t e;
        e.kind = kind;
        e.dat  = m_dout;
        e.cnt  = sat(m_cnt);
        e.flag = m_err;
        e.due  = $time + 14;   // driven at posedge+1, visible at the following negedge
        sb.push_back(e);
    endtask

    task automatic model_reset();
        win.delete();
        m_cnt  = 0;
        m_err  = 1'b0;
        m_dout = 1'b1;
    endtask

    task automatic model(input logic tick, input logic b, input logic en, input logic fs);
        if (fs) begin
            m_cnt = 0;
            m_err = 1'b0;
            win.delete();
        end
        if (!tick) return;
        if (m_err) return;
        if (stuff_due()) begin
            if (b != win[win.size() - 1]) begin
                m_cnt++;
                win.delete();
                win.push_back(b);
                push_exp(1);
            end else begin
                m_err = 1'b1;
                push_exp(2);
            end
        end else begin
            m_dout = b;
            if (en) begin
                win.push_back(b);
                if (win.size() > SL) void'(win.pop_front());
            end else begin
                win.delete();
            end
            push_exp(0);
        end
    endtask

    task automatic step(input logic tick, input logic b, input logic en, input logic fs);
        @(posedge clk);
        #1;
        bus.sample_tick  = tick;
        bus.rx_bit       = b;
        bus.stuff_enable = en;
        bus.frame_start  = fs;
        model(tick, b, en, fs);
    endtask

    task automatic check_levels(input string name);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check({name, "_stuff_count"}, 32'(bus.stuff_count), 32'(sat(m_cnt)));
        check({name, "_error_flag"}, 32'(bus.error_flag), 32'(m_err));
    endtask

    // Monitor: every strobe is matched against the oldest expected event.
    initial begin
        exp_t e;
        logic [12:0] got, want;
        forever begin
            @(negedge clk);
            if (rst && (bus.bit_tick || bus.stuff_drop || bus.stuff_error)) begin
                got = {bus.bit_tick, bus.stuff_drop, bus.stuff_error, bus.data_out,
                       bus.error_flag, bus.stuff_count};
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h expected no strobe", got);
                end else begin
                    e = sb.pop_front();
                    want = {e.kind == 0, e.kind == 1, e.kind == 2, e.dat, e.flag, 8'(e.cnt)};
                    check("output_event", 32'(got), 32'(want));
                end
            end else if (sb.size() > 0 && sb[0].due <= $time) begin
                e = sb.pop_front();
                n_checks++;
                $display("FAIL missing_output: got no strobe expected kind %0d at %0t", e.kind, e.due);
            end
        end
    end

    initial begin
        logic cur;
        logic prev;
        int   len;
        int   en_len;

        bus.sample_tick  = 1'b0;
        bus.rx_bit       = 1'b1;
        bus.stuff_enable = 1'b0;
        bus.frame_start  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_bit_tick",    32'(bus.bit_tick),    32'd0);
        check("rst_data_out",    32'(bus.data_out),    32'd1);
        check("rst_stuff_drop",  32'(bus.stuff_drop),  32'd0);
        check("rst_stuff_error", 32'(bus.stuff_error), 32'd0);
        check("rst_error_flag",  32'(bus.error_flag),  32'd0);
        check("rst_stuff_count", 32'(bus.stuff_count), 32'd0);
        rst = 1'b1;

        // Five dominant bits, recessive stuff, then a dominant data bit.
        step(1, 0, 1, 1);
        repeat (4) step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        check_levels("one_stuff");

        // Sixth identical recessive bit is a violation; later samples ignored.
        step(1, 1, 1, 1);
        repeat (4) step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        repeat (3) step(1, 0, 1, 0);
        check_levels("stuff_err");
        step(0, 1, 0, 1);
        check_levels("err_cleared");

        // Stuff bit opens the next run.
        step(1, 0, 1, 1);
        repeat (4) step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        repeat (4) step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        check_levels("chained_stuff");

        // Stuff region closes on the 5th identical bit; trailing stuff still dropped.
        step(1, 0, 1, 1);
        repeat (4) step(1, 0, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        repeat (2) step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        check_levels("enable_fall");

        // Asynchronous reset while a stuff bit is pending.
        step(1, 0, 1, 1);
        repeat (4) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_bit_tick",    32'(bus.bit_tick),    32'd0);
        check("midrst_data_out",    32'(bus.data_out),    32'd1);
        check("midrst_stuff_drop",  32'(bus.stuff_drop),  32'd0);
        check("midrst_stuff_error", 32'(bus.stuff_error), 32'd0);
        check("midrst_error_flag",  32'(bus.error_flag),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        check_levels("post_rst");

        // 300 stuff bits in one frame: counter saturates, SOF clears it.
        cur = 1'b0;
        step(1, cur, 1, 1);
        repeat (4) step(1, cur, 1, 0);
        for (int k = 0; k < 300; k++) begin
            cur = ~cur;
            step(1, cur, 1, 0);
            repeat (4) step(1, cur, 1, 0);
        end
        check_levels("saturate");
        step(0, 1, 0, 1);
        check_levels("sat_cleared");

        // Random frames with long runs, mostly legal stuffing.
        for (int f = 0; f < 40; f++) begin
            len    = $urandom_range(10, 80);
            en_len = len - $urandom_range(0, 5);
            prev   = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if (i > 0 && $urandom_range(0, 6) == 0) begin
                    step(0, prev, i < en_len, 1'b0);
                end else begin
                    if (i > 0 && stuff_due() && $urandom_range(0, 9) != 0) cur = ~win[win.size() - 1];
                    else if ($urandom_range(0, 3) != 0) cur = prev;
                    else cur = 1'($urandom_range(0, 1));
                    step(1, cur, i < en_len, i == 0);
                    prev = cur;
                end
            end
            if (f % 8 == 7) check_levels("rand_frame");
        end

        repeat (4) step(0, 1, 0, 0);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/can_bit_destuff.md
CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

Interface
REQ-001 SHALL have parameter STUFF_LEN, default 5: number of identical consecutive bits that forces a stuff bit.
REQ-002 SHALL have parameter CNT_W, default 8: width of the per-frame stuff-bit counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sample_tick, input, 1: 1-cycle pulse, a sampled bus bit is valid on rx_bit.
REQ-006 SHALL have port rx_bit, input, 1: sampled bus level (0 = dominant).
REQ-007 SHALL have port stuff_enable, input, 1: HIGH while the current bit lies in the stuffed region (SOF through CRC sequence).
REQ-008 SHALL have port frame_start, input, 1: 1-cycle pulse marking the SOF sample; re-arms the block.
REQ-009 SHALL have port bit_tick, output, 1: 1-cycle pulse, a destuffed data bit is valid on data_out.
REQ-010 SHALL have port data_out, output, 1: destuffed bit, held until the next bit_tick.
REQ-011 SHALL have port stuff_drop, output, 1: 1-cycle pulse, a stuff bit was removed.
REQ-012 SHALL have port stuff_error, output, 1: 1-cycle pulse on a stuff-rule violation.
REQ-013 SHALL have port error_flag, output, 1: sticky violation flag, cleared by frame_start.
REQ-014 SHALL have port stuff_count, output, CNT_W: stuff bits removed in the current frame, saturating.

Function
REQ-015 SHALL implement states IDLE, COUNT, EXPECT_STUFF and ERROR, plus registers last_bit and run_cnt (range 0..STUFF_LEN).
REQ-016 SHALL drive all outputs from registers; bit_tick, stuff_drop and stuff_error assert exactly 1 cycle after the causing sample_tick.
REQ-017 SHALL, in IDLE or COUNT with stuff_enable low, pass every sample through (bit_tick, data_out=rx_bit), force run_cnt=0 and go to IDLE.
REQ-018 SHALL, on sample_tick with stuff_enable high in IDLE/COUNT, emit the bit; rx_bit==last_bit and run_cnt>0 increments run_cnt, otherwise run_cnt=1; last_bit<=rx_bit; state COUNT.
REQ-019 SHALL move to EXPECT_STUFF in the same update in which run_cnt reaches STUFF_LEN.
REQ-020 SHALL, in EXPECT_STUFF on sample_tick with rx_bit!=last_bit, suppress bit_tick, pulse stuff_drop, increment stuff_count (saturate at all-ones), set run_cnt=1, last_bit<=rx_bit, and return to COUNT.
REQ-021 SHALL, in EXPECT_STUFF on sample_tick with rx_bit==last_bit, suppress bit_tick, pulse stuff_error, set error_flag and enter ERROR.
REQ-022 SHALL treat the sample following EXPECT_STUFF as a stuff bit regardless of stuff_enable, covering a stuff bit after the last CRC bit.
REQ-023 SHALL, in ERROR, produce no bit_tick or stuff_drop and ignore samples until frame_start.
REQ-024 SHALL, on frame_start from any state, clear error_flag and stuff_count and process a coincident sample_tick as the first bit of the frame (run_cnt=1, last_bit=rx_bit, bit emitted, state COUNT when stuff_enable is high).
REQ-025 SHALL ignore frame_start without sample_tick apart from clearing, and enter IDLE with run_cnt=0.
REQ-026 SHALL leave all registers unchanged in cycles without sample_tick or frame_start.

Reset
REQ-027 SHALL, with rst low, asynchronously force state=IDLE, run_cnt=0, last_bit=1, data_out=1, bit_tick=0, stuff_drop=0, stuff_error=0, error_flag=0 and stuff_count=0.
REQ-028 SHALL, on reset asserted mid-run (including EXPECT_STUFF), discard the pending stuff expectation; the first post-reset sample is handled per REQ-017/REQ-018.

Structure
REQ-029 SHALL take the state enumeration and default STUFF_LEN from the shared package can_pkg, alongside the existing CRC polynomial constant.
REQ-030 SHALL be a single module with no sub-module; its bit_tick/data_out feed the CRC stage's bit_tick/data_in directly.

Verification
REQ-031 SHALL cover: frame_start+stuff_enable, bits 0,0,0,0,0,1,0 -> 6 bit_ticks (0,0,0,0,0,0), one stuff_drop on the 6th sample, stuff_count=1.
REQ-032 SHALL cover: bits 1×5 then 1 -> stuff_error pulse on the 6th sample, error_flag=1, no further bit_tick until frame_start.
REQ-033 SHALL cover: 0×5, stuff 1, then 1,1,1,1 -> stuff bit counts as run start; 4 more 1s → EXPECT_STUFF, next 0 dropped, stuff_count=2.
REQ-034 SHALL cover: stuff_enable falls on the 5th identical bit -> next opposite sample dropped as stuff; a sample with stuff_enable low and run_cnt<5 passes through.
REQ-035 SHALL cover: rst low while in EXPECT_STUFF -> all outputs zero and data_out=1 immediately; the first post-reset sample is emitted, not dropped.
REQ-036 SHALL cover: 300 stuff bits in one frame with CNT_W=8 -> stuff_count saturates at 255; a subsequent frame_start clears it to 0.
